// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge detector: edge mode encodings
// and a constant-evaluable ceiling log2.
package edge_pkg;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One edge-detector channel: input synchroniser, debounce filter, mode-qualified
// edge strobe, sticky event flag and saturating event counter.
module edge_chan
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic [1:0]       mode,
    input  logic             sticky_clr,
    input  logic             cnt_clr,
    output logic             level,
    output logic             pulse,
    output logic             sticky,
    output logic [CNT_W-1:0] cnt
);

    localparam int DB_W = clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic            s;
    logic            f;
    logic [DB_W-1:0] c;
    logic            accept;
    logic            hit;
    logic            pulse_q;
    logic            sticky_q;
    logic [CNT_W-1:0] cnt_q;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = din;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sr;
            always_ff @(posedge clk) begin
                if (rst) begin
                    sr <= '0;
                end else begin
                    sr[0] <= din;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sr[k] <= sr[k-1];
                    end
                end
            end
            assign s = sr[SYNC_STAGES-1];
        end
    endgenerate

    // The new value is accepted on the same edge that the registered strobe fires.
    always_comb begin
        accept = (s != f) && (c == DB_LAST);
        hit    = 1'b0;
        if (accept) begin
            case (mode)
                EDGE_RISE: hit = s;
                EDGE_FALL: hit = ~s;
                EDGE_BOTH: hit = 1'b1;
                EDGE_OFF:  hit = 1'b0;
                default:   hit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f <= 1'b0;
            c <= '0;
        end else if (s == f) begin
            c <= '0;
        end else if (accept) begin
            f <= s;
            c <= '0;
        end else begin
            c <= c + 1'b1;
        end
    end

    // Sticky and counter follow the registered strobe, so set/increment beat clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q  <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pulse_q  <= hit;
            sticky_q <= pulse_q | (sticky_q & ~sticky_clr);
            if (cnt_clr) begin
                cnt_q <= pulse_q ? CNT_W'(1) : '0;
            end else if (pulse_q && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level  = f;
    assign pulse  = pulse_q;
    assign sticky = sticky_q;
    assign cnt    = cnt_q;

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: an array of independent edge_chan instances
// with per-channel slicing of the packed mode and counter buses.
module edge_detect_multi
    import edge_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       din,
    input  logic [2*N_CH-1:0]     mode,
    output logic [N_CH-1:0]       level,
    output logic [N_CH-1:0]       pulse,
    output logic [N_CH-1:0]       sticky,
    input  logic [N_CH-1:0]       sticky_clr,
    output logic [N_CH*CNT_W-1:0] cnt,
    input  logic                  cnt_clr
);

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            edge_chan #(
                .SYNC_STAGES(SYNC_STAGES),
                .DB_CYCLES  (DB_CYCLES),
                .CNT_W      (CNT_W)
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .din       (din[i]),
                .mode      (mode[2*i +: 2]),
                .sticky_clr(sticky_clr[i]),
                .cnt_clr   (cnt_clr),
                .level     (level[i]),
                .pulse     (pulse[i]),
                .sticky    (sticky[i]),
                .cnt       (cnt[CNT_W*i +: CNT_W])
            );
        end
    endgenerate

endmodule

// File: doc/edge_detect_multi.md
# edge_detect_multi

Parametrised multi-channel edge detector: each channel synchronises an asynchronous input, debounces it, and detects rising, falling or both edges under a per-channel runtime mode. It also keeps a sticky event flag and a saturating event counter. It generalises the single-bit negative-edge detector in the general library and sits between raw board or ADC-status inputs and register or interrupt logic.

## Interface
- `N_CH`, 8, number of independent channels (≥1)
- `SYNC_STAGES`, 2, synchroniser flops per channel; 0 = input used directly (already synchronous)
- `DB_CYCLES`, 4, consecutive cycles a changed value must persist before acceptance (≥1; 1 = no filtering)
- `CNT_W`, 16, event counter width per channel
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `din`  in  N_CH  raw channel inputs
- `mode`  in  2*N_CH  per-channel mode, channel i at [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
- `level`  out  N_CH  debounced channel state
- `pulse`  out  N_CH  one-cycle strobe per qualifying edge
- `sticky`  out  N_CH  latched event flag
- `sticky_clr`  in  N_CH  per-channel sticky clear
- `cnt`  out  N_CH*CNT_W  event counters, channel i at [CNT_W*(i+1)-1:CNT_W*i]
- `cnt_clr`  in  1  clears all counters

## Operation
- Sync: SYNC_STAGES-deep flop chain per channel gives s[i].
- Debounce: per channel, filtered state f[i] (= `level[i]`) and counter c[i] of width clog2(DB_CYCLES+1).
  - If s == f: c <= 0.
  - Else if c == DB_CYCLES-1: f <= s, c <= 0.
  - Else: c <= c+1.
  - Any bounce back to f before acceptance restarts the count.
- Detect: `pulse[i]` is registered. It is 1 exactly on the edge where f updates and the direction matches `mode[i]`:
  - rise needs f 0→1; fall needs 1→0; both accepts either; off never pulses.
- Mode changes take effect on the next clock edge. A mode change never generates a pulse by itself. `level` is tracked regardless of mode.
- Sticky: set when `pulse[i]`=1; cleared by `sticky_clr[i]`. Simultaneous set and clear → stays 1 (set wins).
- Counter: increments on `pulse[i]` and saturates at 2^CNT_W-1 with no wrap. `cnt_clr` zeroes all counters. If `cnt_clr` and `pulse[i]` occur together → cnt[i] = 1.

## Timing
- Reset: all sync flops, f, c, `pulse`, `sticky` and `cnt` go to 0 on the first clk edge with `rst`=1.
- `rst` mid-debounce discards partial counts. No pulse is emitted for a transition interrupted by reset.
- A channel held high across reset release is seen as a rising edge. Its `pulse` asserts SYNC_STAGES+DB_CYCLES edges after the first edge with `rst`=0.
- Latency: `din` stable from just before edge 1 → `level` and `pulse` change at edge SYNC_STAGES+DB_CYCLES. `pulse` is high for exactly one cycle.
- `sticky` and `cnt` update one edge after `pulse` (registered from `pulse`).
- Minimum accepted pulse width is DB_CYCLES cycles. Shorter glitches produce no `level` change and no event.
- Max event rate per channel: one per DB_CYCLES cycles. Channels are fully independent, and simultaneous events on all channels are all counted.

## Structure
- Shared package `edge_pkg`: mode constants EDGE_OFF=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11, plus a clog2 function.
- Sub-module `edge_chan`: one channel covering sync, debounce, detect, sticky and counter, with the same parameters minus N_CH.
- The top level is a generate loop over `edge_chan` plus port slicing only.

## Test plan
- Defaults; `rst` with `din`=0, release, ch0 mode=01, `din[0]` 0→1 held → `level[0]`=1 and one-cycle `pulse[0]` at edge 6 after change; `sticky[0]`=1 and `cnt[0]`=1 at edge 7.
- ch1 mode=10, `din[1]` high pulse of 3 cycles (< DB_CYCLES=4) → no `level`/`pulse` change; 4-cycle high then low → two `level` transitions, exactly one `pulse` (the fall).
- ch2 mode=11, 5 clean toggles spaced 10 cycles → 5 pulses, `cnt[2]`=5. Switch to mode=00, 2 more toggles → `cnt[2]` stays 5 while `level` still tracks.
- CNT_W=3, 9 qualifying edges → `cnt` saturates at 7. `cnt_clr` coincident with a pulse → `cnt`=1. `sticky_clr` coincident with `pulse` → `sticky` stays 1.
- `din` held high through reset → pulse at SYNC_STAGES+DB_CYCLES edges after release. Assert `rst` at c=2 mid-debounce → no pulse; all outputs 0 one edge after `rst`.
- SYNC_STAGES=0, DB_CYCLES=1, N_CH=1: `din` 0→1 before edge k → `pulse` at edge k, matching a plain registered edge detector.
